// File: rtl/sram_dma.sv
// rtl/sram_dma.sv - single-port SRAM DMA engine: ascending word copy or constant fill
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : transfer request, sampled only while idle
//   mode             : 0 = copy src -> dst, 1 = fill dst with fill
//   src, dst, len    : first source/destination address and word count
//   fill             : fill value
//   busy, done       : busy in every non-idle state; done pulses for one cycle
//   mem_we, mem_a    : SRAM write enable and address
//   mem_din          : SRAM write data
//   mem_dout         : SRAM combinational read data of mem[mem_a]
module sram_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill,
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            fill_q    <= '0;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
        end
    end

    // Operands are only loaded in IDLE, so a transfer in flight cannot be
    // disturbed by start or by the operand inputs changing.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    fill_d    = fill;
                    src_ptr_d = src;
                    dst_ptr_d = dst;
                    cnt_d     = len;
                    if (len == '0) begin
                        state_d = FIN;
                    end else if (mode) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                data_d  = mem_dout;
                state_d = WR;
            end
            WR: begin
                dst_ptr_d = dst_ptr_q + ONE;
                if (!mode_q) begin
                    src_ptr_d = src_ptr_q + ONE;
                end
                cnt_d = cnt_q - ONE;
                // cnt_q is never zero here: LEN=0 bypasses RD/WR entirely.
                if (cnt_q == ONE) begin
                    state_d = FIN;
                end else if (mode_q) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs decode the registered state only, so the
    // asynchronous reset clears them immediately and start never reaches them.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == FIN);
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_din = '0;
        case (state_q)
            RD: begin
                mem_a = src_ptr_q;
            end
            WR: begin
                mem_we  = 1'b1;
                mem_a   = dst_ptr_q;
                mem_din = mode_q ? fill_q : data_q;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/sram_dma.md
SRAM_DMA -- requirements
Module: sram_dma

Interface
REQ-001 Parameter: AW, default 16, SRAM address width in bits.
REQ-002 Parameter: DW, default 16, SRAM data width in bits.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request a transfer; sampled only in IDLE.
REQ-006 MODE  input  1  transfer type: 0 = copy SRC to DST, 1 = fill DST with FILL.
REQ-007 SRC  input  AW  first source address (copy only).
REQ-008 DST  input  AW  first destination address.
REQ-009 LEN  input  AW  word count; 0 = no memory access.
REQ-010 FILL  input  DW  fill value (fill only).
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 MEM_WE  output  1  write enable to SRAM WE.
REQ-014 MEM_A  output  AW  address to SRAM A.
REQ-015 MEM_DIN  output  DW  write data to SRAM Din.
REQ-016 MEM_DOUT  input  DW  SRAM Dout; combinational read of mem[MEM_A].

Function
REQ-017 FSM states SHALL be IDLE, RD, WR and FIN, held in a registered state variable.
REQ-018 In IDLE with START=1, MODE, SRC, DST, LEN and FILL SHALL be latched at the edge.
  - Next state FIN if LEN=0.
  - Otherwise RD if MODE=0, or WR if MODE=1.
REQ-019 START SHALL be ignored in RD, WR and FIN; latched operands SHALL NOT change during a transfer.
REQ-020 RD: MEM_A = src pointer, MEM_WE=0; at the edge, MEM_DOUT is captured into the data register and the next state is WR.
REQ-021 WR: MEM_A = dst pointer, MEM_WE=1, MEM_DIN = data register (copy) or latched FILL (fill).
  - Edge action: dst pointer +1, src pointer +1 (copy only), remaining count -1.
REQ-022 After a WR, next state SHALL be FIN if remaining count reaches 0, else RD (copy) or WR (fill).
REQ-023 FIN: DONE=1 and BUSY=1 for exactly one cycle; the next state is IDLE.
REQ-024 Throughput and latency for N>0 words:
  - Copy: 2 cycles per word; DONE appears 2N+1 cycles after the START edge.
  - Fill: 1 cycle per word; DONE appears N+1 cycles after the START edge.
  - LEN=0: DONE appears 1 cycle after the START edge.
REQ-025 Pointers SHALL wrap modulo 2^AW (0xFFFF+1 = 0x0000); LEN counts words, not an end address.
REQ-026 Copy SHALL run ascending, word by word: each word is read immediately before it is written.
  - Overlapping regions with DST>SRC therefore propagate earlier words; this is defined behaviour.
REQ-027 In IDLE and FIN: MEM_WE=0, MEM_A=0, MEM_DIN=0.
REQ-028 MEM_WE SHALL be high only in WR, decoded from registered state only, with no combinational path from START.

Reset
REQ-029 RST_N=0 SHALL immediately and asynchronously drive:
  - state to IDLE, and BUSY, DONE and MEM_WE to 0;
  - MEM_A, MEM_DIN, the pointers, the count and the data register to 0.
REQ-030 Reset in the middle of a transfer SHALL abort it with no further writes and no DONE; words already written remain in memory.
REQ-031 After RST_N rises, the first START SHALL be accepted at the first rising edge on which it is sampled high in IDLE.

Verification
REQ-032 Preload mem[0x0010..0x0013] = 0xA001..0xA004; copy SRC=0x0010, DST=0x0100, LEN=4.
  - Required: mem[0x0100..0x0103] = 0xA001..0xA004, BUSY high for 9 cycles, single DONE pulse on cycle 9.
REQ-033 Fill DST=0xFFFE, LEN=3, FILL=0x5A5A.
  - Required: mem[0xFFFE], mem[0xFFFF] and mem[0x0000] = 0x5A5A; mem[0x0001] unchanged; DONE on cycle 4.
REQ-034 LEN=0 in either mode.
  - Required: MEM_WE never asserted, DONE one cycle after START, IDLE on the following cycle.
REQ-035 Hold START high for the whole of a copy with LEN=2, and change SRC mid-transfer.
  - Required: only the first request executes with the originally latched SRC; a second transfer starts on the first edge back in IDLE.
REQ-036 Pull RST_N low during the WR of word 2 of a LEN=4 fill.
  - Required: MEM_WE falls without waiting for a clock edge; only words 0-1 are written (plus word 2 only if its edge already occurred); no DONE; BUSY=0.
REQ-037 Overlapping copy SRC=0x0020, DST=0x0021, LEN=3 with mem[0x0020]=0x1111.
  - Required: mem[0x0021..0x0023] = 0x1111.
